// File: rtl/alu_arbiter_pkg.sv
// Shared datapath definitions for the two-requester ALU arbiter:
// operand/result widths, ALU control codes and response buffer states.
package alu_arbiter_pkg;

  localparam int OP_W   = 16;
  localparam int RES_W  = 32;
  localparam int CTRL_W = 3;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_MOVE = 3'b010,
    ALU_SWAP = 3'b011,
    ALU_AND  = 3'b100,
    ALU_OR   = 3'b101
  } alu_ctrl_e;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright, and on
// contention the requester that was not granted most recently wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_gnt,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_gnt ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters and
// buffers a single registered response with valid/ready handshake.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req0_op1,
  input  logic [OP_W-1:0]   req0_op2,
  input  logic [OP_W-1:0]   req1_op1,
  input  logic [OP_W-1:0]   req1_op2,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic [OP_W-1:0]   alu_op1,
  output logic [OP_W-1:0]   alu_op2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [RES_W-1:0]  alu_result,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_overflow,
  input  logic              rsp_ready,
  output logic [CNT_W-1:0]  ovf_count
);

  rsp_state_e       state_q, state_d;
  logic             lastGnt_q, lastGnt_d;
  logic             rspId_q, rspId_d;
  logic [RES_W-1:0] rspResult_q, rspResult_d;
  logic             rspOvf_q, rspOvf_d;
  logic [CNT_W-1:0] ovfCount_q, ovfCount_d;

  logic [1:0] grant;
  logic       canAccept;
  logic       accept;

  rr_arb2 u_rr_arb2 (
    .valid    ({req1_valid, req0_valid}),
    .last_gnt (lastGnt_q),
    .grant    (grant)
  );

  // Ready is gated by rst_n so nothing handshakes while reset is held.
  always_comb begin
    canAccept  = (state_q == RSP_EMPTY) | rsp_ready;
    req0_ready = grant[0] & canAccept & rst_n;
    req1_ready = grant[1] & canAccept & rst_n;
    accept     = req0_ready | req1_ready;

    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = ALU_MOVE;
    if (grant[0]) begin
      alu_op1  = req0_op1;
      alu_op2  = req0_op2;
      alu_ctrl = req0_ctrl;
    end else if (grant[1]) begin
      alu_op1  = req1_op1;
      alu_op2  = req1_op2;
      alu_ctrl = req1_ctrl;
    end
  end

  always_comb begin
    state_d     = state_q;
    lastGnt_d   = lastGnt_q;
    rspId_d     = rspId_q;
    rspResult_d = rspResult_q;
    rspOvf_d    = rspOvf_q;
    ovfCount_d  = ovfCount_q;

    unique case (state_q)
      RSP_EMPTY: if (accept) state_d = RSP_FULL;
      RSP_FULL:  if (!accept && rsp_ready) state_d = RSP_EMPTY;
      default:   state_d = RSP_EMPTY;
    endcase

    if (accept) begin
      lastGnt_d   = req1_ready;
      rspId_d     = req1_ready;
      rspResult_d = alu_result;
      rspOvf_d    = alu_overflow;
      if (alu_overflow && (ovfCount_q != {CNT_W{1'b1}}))
        ovfCount_d = ovfCount_q + CNT_W'(1);
    end
  end

  // last_gnt resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RSP_EMPTY;
      lastGnt_q   <= 1'b1;
      rspId_q     <= 1'b0;
      rspResult_q <= '0;
      rspOvf_q    <= 1'b0;
      ovfCount_q  <= '0;
    end else begin
      state_q     <= state_d;
      lastGnt_q   <= lastGnt_d;
      rspId_q     <= rspId_d;
      rspResult_q <= rspResult_d;
      rspOvf_q    <= rspOvf_d;
      ovfCount_q  <= ovfCount_d;
    end
  end

  assign rsp_valid    = (state_q == RSP_FULL);
  assign rsp_id       = rspId_q;
  assign rsp_result   = rspResult_q;
  assign rsp_overflow = rspOvf_q;
  assign ovf_count    = ovfCount_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the
// external ALU driving alu_result/alu_overflow.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        req0_ready, req1_ready;
  logic [15:0] alu_op1, alu_op2;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        rsp_valid, rsp_id, rsp_overflow, rsp_ready;
  logic [31:0] rsp_result;
  logic [7:0]  ovf_count;

  int totalChecks = 0;
  int badChecks   = 0;

  alu_arbiter #(.CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req1_valid   (req1_valid),
    .req0_op1     (req0_op1),
    .req0_op2     (req0_op2),
    .req1_op1     (req1_op1),
    .req1_op2     (req1_op2),
    .req0_ctrl    (req0_ctrl),
    .req1_ctrl    (req1_ctrl),
    .req0_ready   (req0_ready),
    .req1_ready   (req1_ready),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_ready    (rsp_ready),
    .ovf_count    (ovf_count)
  );

  always #5 clk = ~clk;

  // Reference ALU: 16-bit signed add/sub with sign-extended result.
  logic [15:0] sum16, diff16;
  always_comb begin
    sum16        = alu_op1 + alu_op2;
    diff16       = alu_op1 - alu_op2;
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      ALU_ADD: begin
        alu_result   = {{16{sum16[15]}}, sum16};
        alu_overflow = (alu_op1[15] == alu_op2[15]) && (sum16[15] != alu_op1[15]);
      end
      ALU_SUB: begin
        alu_result   = {{16{diff16[15]}}, diff16};
        alu_overflow = (alu_op1[15] != alu_op2[15]) && (diff16[15] != alu_op1[15]);
      end
      ALU_MOVE: alu_result = {16'h0000, alu_op1};
      ALU_SWAP: alu_result = {alu_op2, alu_op1};
      ALU_AND:  alu_result = {16'h0000, alu_op1 & alu_op2};
      default:  alu_result = {16'h0000, alu_op1 | alu_op2};
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                               input logic [2:0] c0, input logic v1, input logic [15:0] a1,
                               input logic [15:0] b1, input logic [2:0] c1, input logic rr);
    req0_valid = v0; req0_op1 = a0; req0_op2 = b0; req0_ctrl = c0;
    req1_valid = v1; req1_op1 = a1; req1_op2 = b1; req1_ctrl = c1;
    rsp_ready  = rr;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'd0, 16'd0, ALU_ADD, 1'b0, 16'd0, 16'd0, ALU_ADD, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values, with a request already pending to prove ready is held low
    rst_n = 1'b0;
    applyStimulus(1'b1, 16'd5, 16'd3, ALU_ADD, 1'b0, 16'd0, 16'd0, ALU_ADD, 1'b1);
    #2;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_rsp_result", rsp_result, 32'd0);
    checkOutput("rst_rsp_ovf", 32'(rsp_overflow), 32'd0);
    checkOutput("rst_ovf_count", 32'(ovf_count), 32'd0);
    checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single requester 0: 5 + 3
    @(negedge clk);
    checkOutput("add_req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("add_req1_ready", 32'(req1_ready), 32'd0);
    checkOutput("add_alu_op1", 32'(alu_op1), 32'd5);
    checkOutput("add_rsp_valid_pre", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 16'd0, 16'd0, ALU_ADD, 1'b0, 16'd0, 16'd0, ALU_ADD, 1'b1);
    @(negedge clk);
    checkOutput("add_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("add_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("add_rsp_result", rsp_result, 32'h00000008);
    checkOutput("add_rsp_ovf", 32'(rsp_overflow), 32'd0);
    checkOutput("idle_alu_ctrl", 32'(alu_ctrl), 32'd2);
    checkOutput("idle_alu_op1", 32'(alu_op1), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("drain_rsp_valid", 32'(rsp_valid), 32'd0);

    // Round-robin alternation with back-to-back responses
    doReset();
    applyStimulus(1'b1, 16'd1, 16'd2, ALU_ADD, 1'b1, 16'd10, 16'd4, ALU_SUB, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rr_ready0_%0d", k), 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr_ready1_%0d", k), 32'(req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k == 0) begin
        checkOutput("rr_rsp_valid_0", 32'(rsp_valid), 32'd0);
      end else begin
        checkOutput($sformatf("rr_rsp_valid_%0d", k), 32'(rsp_valid), 32'd1);
        checkOutput($sformatf("rr_rsp_id_%0d", k), 32'(rsp_id), 32'((k - 1) % 2));
        checkOutput($sformatf("rr_rsp_result_%0d", k), rsp_result,
                    ((k - 1) % 2 == 0) ? 32'd3 : 32'd6);
      end
      @(posedge clk); #1;
    end

    // Stall: response from requester 1 held, both requesters blocked
    rsp_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_ready0_%0d", s), 32'(req0_ready), 32'd0);
      checkOutput($sformatf("stall_ready1_%0d", s), 32'(req1_ready), 32'd0);
      checkOutput($sformatf("stall_rsp_valid_%0d", s), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("stall_rsp_id_%0d", s), 32'(rsp_id), 32'd1);
      checkOutput($sformatf("stall_rsp_result_%0d", s), rsp_result, 32'd6);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("unstall_ready0", 32'(req0_ready), 32'd1);
    checkOutput("unstall_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 16'd0, 16'd0, ALU_ADD, 1'b0, 16'd0, 16'd0, ALU_ADD, 1'b1);
    @(negedge clk);
    checkOutput("unstall_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("unstall_rsp_result", rsp_result, 32'd3);

    // Overflow counting and saturation
    doReset();
    applyStimulus(1'b0, 16'd0, 16'd0, ALU_ADD, 1'b1, 16'h7FFF, 16'h0001, ALU_ADD, 1'b1);
    @(negedge clk);
    checkOutput("ovf_req1_ready", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 16'd5, 16'd3, ALU_ADD, 1'b0, 16'd0, 16'd0, ALU_ADD, 1'b1);
    @(negedge clk);
    checkOutput("ovf_rsp_ovf", 32'(rsp_overflow), 32'd1);
    checkOutput("ovf_rsp_id", 32'(rsp_id), 32'd1);
    checkOutput("ovf_count_1", 32'(ovf_count), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 16'd0, 16'd0, ALU_ADD, 1'b1, 16'h7FFF, 16'h0001, ALU_ADD, 1'b1);
    @(negedge clk);
    checkOutput("noovf_rsp_ovf", 32'(rsp_overflow), 32'd0);
    checkOutput("noovf_count", 32'(ovf_count), 32'd1);
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 253 || i == 254 || i == 300)
        checkOutput($sformatf("sat_count_%0d", i), 32'(ovf_count),
                    (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end

    // Asynchronous reset while a response is held
    @(posedge clk); #1;
    applyStimulus(1'b0, 16'd0, 16'd0, ALU_ADD, 1'b0, 16'd0, 16'd0, ALU_ADD, 1'b0);
    @(negedge clk);
    checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    applyStimulus(1'b1, 16'd1, 16'd2, ALU_ADD, 1'b1, 16'd10, 16'd4, ALU_SUB, 1'b0);
    #1;
    checkOutput("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("arst_ovf_count", 32'(ovf_count), 32'd0);
    checkOutput("arst_req0_ready", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("post_rst_ready0", 32'(req0_ready), 32'd1);
    checkOutput("post_rst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 16'd0, 16'd0, ALU_ADD, 1'b0, 16'd0, 16'd0, ALU_ADD, 1'b1);
    @(negedge clk);
    checkOutput("post_rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("post_rst_rsp_result", rsp_result, 32'd3);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the saturating overflow event counter.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 each, requester N presents an operation.
REQ-005 SHALL have ports req0_op1, req0_op2, req1_op1, req1_op2, input, 16 each, signed operands.
REQ-006 SHALL have ports req0_ctrl / req1_ctrl, input, 3 each, ALU control code (000 ADD, 001 SUB, 010 MOVE, 011 SWAP, 100 AND, 101-111 OR).
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1 each, operation accepted this cycle when ready and valid are both high.
REQ-008 SHALL have ports alu_op1 / alu_op2, output, 16 each, and alu_ctrl, output, 3, driven to the shared external ALU.
REQ-009 SHALL have ports alu_result, input, 32, and alu_overflow, input, 1, combinational returns from the ALU.
REQ-010 SHALL have ports rsp_valid, output, 1; rsp_id, output, 1 (requester index); rsp_result, output, 32; rsp_overflow, output, 1; rsp_ready, input, 1.
REQ-011 SHALL have port ovf_count, output, CNT_W, number of accepted operations whose ALU overflow was high.

Function
REQ-012 SHALL compute can_accept = !rsp_valid | rsp_ready; no request is accepted when can_accept is low.
REQ-013 SHALL grant at most one requester per cycle; only one valid -> that one; both valid -> the one not granted most recently (round-robin pointer last_gnt).
REQ-014 SHALL drive reqN_ready = grant_N & can_accept, combinationally; ready SHALL not depend on rsp_ready beyond can_accept.
REQ-015 SHALL drive alu_op1/alu_op2/alu_ctrl from the granted requester's inputs; with no grant, drive zeros and ctrl 3'b010.
REQ-016 SHALL, on acceptance in cycle N, register alu_result, alu_overflow and the requester index into rsp_result, rsp_overflow, rsp_id and assert rsp_valid in cycle N+1 (latency 1).
REQ-017 SHALL update last_gnt only on an accepted transfer, never on a grant that stalled.
REQ-018 SHALL hold rsp_valid and all rsp_* fields stable until rsp_valid & rsp_ready; simultaneous drain and new accept SHALL load the new response (back-to-back throughput 1 per cycle).
REQ-019 SHALL clear rsp_valid on drain with no simultaneous accept.
REQ-020 SHALL implement two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1); EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on drain with accept or no drain.
REQ-021 SHALL increment ovf_count by 1 per accepted operation with alu_overflow=1, saturating at all-ones with no wrap.
REQ-022 SHALL require requesters to hold valid and operands stable while valid & !ready; a requester dropping valid before acceptance SHALL simply not be served (no error).

Reset
REQ-023 SHALL, while rst_n is low, force rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0, ovf_count=0, state EMPTY, last_gnt=1 (so requester 0 wins the first contention).
REQ-024 SHALL discard any held response when reset asserts mid-operation; no response is delivered after release until a new acceptance.
REQ-025 SHALL keep reqN_ready low while rst_n is low.

Structure
REQ-026 SHALL take ALU control code constants (ADD, SUB, MOVE, SWAP, AND, OR) and the 16-bit operand / 32-bit result widths from the shared datapath package.
REQ-027 SHALL contain the round-robin grant logic as one sub-module rr_arb2 (inputs valid[1:0], last_gnt; output grant[1:0]); the ALU itself stays external.

Verification
REQ-028 Bench SHALL check: req0 only, op1=5, op2=3, ctrl=000, rsp_ready=1 -> req0_ready=1 in cycle N; rsp_valid, rsp_id=0, rsp_result=0x00000008, rsp_overflow=0 in N+1.
REQ-029 Bench SHALL check: both valid every cycle after reset, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1 with no bubble.
REQ-030 Bench SHALL check: rsp_ready=0 with response FULL, both requesting -> both ready low, rsp_* unchanged for 5 cycles, last_gnt unchanged; rsp_ready=1 -> next requester accepted same cycle.
REQ-031 Bench SHALL check: req1 ADD 0x7FFF + 0x0001 -> rsp_overflow=1, ovf_count 0->1; 300 overflowing ADDs -> ovf_count saturates at 255 (CNT_W=8).
REQ-032 Bench SHALL check: rst_n pulsed low while rsp_valid=1 -> rsp_valid=0 and ovf_count=0 immediately (asynchronous); after release, both valid -> requester 0 granted first.
